// File: rtl/alu_pkg.sv
// alu_pkg: shared add/sub mode constants, status flag layout and default pipeline geometry.
package alu_pkg;
    localparam logic ADDSUB_ADD = 1'b0;
    localparam logic ADDSUB_SUB = 1'b1;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: W-bit ripple chunk built from full_adder cells; exports carry-out and carry-into-MSB.
module addsub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o
);
    logic [W:0] c;
    assign c[0] = cin_i;
    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (.sum(sum_o[i]), .cout(c[i+1]), .a(a_i[i]), .b(b_i[i]), .cin(c[i]));
    end
    assign cout_o = c[W];
    assign cmsb_o = c[W-1];
endmodule

// File: rtl/full_adder.sv
// full_adder: 1-bit full-adder cell carried over from the gate-level ripple adder.
module full_adder (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined two's-complement add/sub; stage k adds chunk k and forwards the
// still-unprocessed upper operand chunks, all stages stalling together on a blocked output.
module pipe_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int C = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipe_addsub: WIDTH must be >= 2 and divisible by 1 <= STAGES <= WIDTH");
    end

    logic             adv;
    logic [WIDTH-1:0] bx;
    logic             c0;
    flags_t           fl_q;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign bx       = (sub == ADDSUB_SUB) ? ~b : b;
    assign c0       = (sub == ADDSUB_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int HI = (k + 1) * C;
        logic          vin, v_q, xci, xco, xcm;
        logic [C-1:0]  xa, xb, xs;
        logic [HI-1:0] sum_d, sum_q;

        if (k == 0) begin : g_src
            assign vin   = in_valid;
            assign xa    = a[C-1:0];
            assign xb    = bx[C-1:0];
            assign xci   = c0;
            assign sum_d = xs;
        end else begin : g_src
            assign vin   = g_stg[k-1].v_q;
            assign xa    = g_stg[k-1].g_fwd.ua_q[C-1:0];
            assign xb    = g_stg[k-1].g_fwd.ub_q[C-1:0];
            assign xci   = g_stg[k-1].g_fwd.c_q;
            assign sum_d = {xs, g_stg[k-1].sum_q};
        end

        addsub_slice #(.W(C)) u_slice (
            .a_i(xa), .b_i(xb), .cin_i(xci), .sum_o(xs), .cout_o(xco), .cmsb_o(xcm)
        );

        // data registers only load on a valid beat so a blocked or idle output keeps its last value
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                v_q <= vin;
                if (vin) sum_q <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int UW = WIDTH - HI;
            logic [UW-1:0] ua_d, ub_d, ua_q, ub_q;
            logic          c_q, cmsb_unused;
            assign cmsb_unused = xcm;
            if (k == 0) begin : g_in
                assign ua_d = a[WIDTH-1:HI];
                assign ub_d = bx[WIDTH-1:HI];
            end else begin : g_in
                assign ua_d = g_stg[k-1].g_fwd.ua_q[UW+C-1:C];
                assign ub_d = g_stg[k-1].g_fwd.ub_q[UW+C-1:C];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ua_q <= '0;
                    ub_q <= '0;
                    c_q  <= 1'b0;
                end else if (adv && vin) begin
                    ua_q <= ua_d;
                    ub_q <= ub_d;
                    c_q  <= xco;
                end
            end
        end else begin : g_last
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) fl_q <= '0;
                else if (adv && vin) fl_q <= {xco, xco ^ xcm, ~|sum_d};
            end
        end
    end

    assign out_valid          = g_stg[STAGES-1].v_q;
    assign s                  = g_stg[STAGES-1].sum_q;
    assign {cout, ovf, zero}  = fl_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: four pipe_addsub geometries behind one shared stimulus port, checked against an arithmetic model.
module tb_pipe_addsub;
    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, sub, cin, out_ready;
    logic [31:0] a, b;
    logic [3:0]  iv, ir, ov, co, of, zr;
    logic [7:0]  s0, s1;
    logic [31:0] s2, s3;
    logic [31:0] o_s;
    logic [2:0]  o_f;
    logic        o_ov, o_ir;
    int          sel = 0;
    int          wid [4] = '{8, 8, 32, 32};
    int          stg [4] = '{2, 4, 1, 32};
    int          ncmp = 0, nbad = 0, cyc = 0;
    logic        chk_lat = 1'b1, hold = 1'b0, acc = 1'b0;
    logic [31:0] ps;
    logic [2:0]  pf;
    exp_t        q [$];

    always #5 clk = ~clk;

    assign iv   = in_valid ? 4'(1 << sel) : 4'b0;
    assign o_ov = ov[sel];
    assign o_ir = ir[sel];
    assign o_f  = {co[sel], of[sel], zr[sel]};
    assign o_s  = sel == 0 ? {24'h0, s0} : sel == 1 ? {24'h0, s1} : sel == 2 ? s2 : s3;

    pipe_addsub #(.WIDTH(8), .STAGES(2)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a[7:0]), .b(b[7:0]),
        .sub(sub), .cin(cin), .out_valid(ov[0]), .out_ready(out_ready), .s(s0),
        .cout(co[0]), .ovf(of[0]), .zero(zr[0]));
    pipe_addsub #(.WIDTH(8), .STAGES(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a[7:0]), .b(b[7:0]),
        .sub(sub), .cin(cin), .out_valid(ov[1]), .out_ready(out_ready), .s(s1),
        .cout(co[1]), .ovf(of[1]), .zero(zr[1]));
    pipe_addsub #(.WIDTH(32), .STAGES(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b),
        .sub(sub), .cin(cin), .out_valid(ov[2]), .out_ready(out_ready), .s(s2),
        .cout(co[2]), .ovf(of[2]), .zero(zr[2]));
    pipe_addsub #(.WIDTH(32), .STAGES(32)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .a(a), .b(b),
        .sub(sub), .cin(cin), .out_valid(ov[3]), .out_ready(out_ready), .s(s3),
        .cout(co[3]), .ovf(of[3]), .zero(zr[3]));

    // full-precision sum of the masked operands; overflow from operand/result signs
    function automatic exp_t model(logic [31:0] x, logic [31:0] y, logic sb, logic ci, int w, int t);
        exp_t e;
        longint unsigned m  = (64'd1 << w) - 1;
        longint unsigned xa = {32'h0, x} & m;
        longint unsigned yb = (sb ? {32'h0, ~y} : {32'h0, y}) & m;
        longint unsigned f  = xa + yb + (sb ? 64'd1 : {63'd0, ci});
        longint unsigned r  = f & m;
        e.s = 32'(r);
        e.c = 1'((f >> w) & 1);
        e.o = (((xa >> (w - 1)) & 1) == ((yb >> (w - 1)) & 1)) && (((r >> (w - 1)) & 1) != ((xa >> (w - 1)) & 1));
        e.z = (r == 0);
        e.t = t;
        return e;
    endfunction

    task automatic step();
        exp_t e;
        @(negedge clk);
        ncmp++;
        assert (o_ir === (!o_ov || out_ready))
        else begin nbad++; $error("FAIL in_ready got %b want %b", o_ir, !o_ov || out_ready); end
        if (hold) begin
            ncmp++;
            assert ({o_ov, o_s, o_f} === {1'b1, ps, pf})
            else begin nbad++; $error("FAIL stall_hold got %b/%h/%b want 1/%h/%b", o_ov, o_s, o_f, ps, pf); end
        end
        hold = o_ov && !out_ready;
        ps = o_s;
        pf = o_f;
        if (q.size() == 0) begin
            ncmp++;
            assert (o_ov === 1'b0)
            else begin nbad++; $error("FAIL spurious_valid got %b want 0", o_ov); end
        end else if (o_ov && out_ready) begin
            e = q.pop_front();
            ncmp++;
            assert ({o_s, o_f} === {e.s, e.c, e.o, e.z})
            else begin nbad++; $error("FAIL result got %h/%b want %h/%b", o_s, o_f, e.s, {e.c, e.o, e.z}); end
            if (chk_lat) begin
                ncmp++;
                assert (cyc - e.t === stg[sel])
                else begin nbad++; $error("FAIL latency got %0d want %0d", cyc - e.t, stg[sel]); end
            end
        end
        acc = in_valid && o_ir;
        if (acc) q.push_back(model(a, b, sub, cin, wid[sel], cyc));
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        a   = $urandom;
        b   = $urandom;
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && q.size() > 0; i++) step();
        ncmp++;
        assert (q.size() == 0)
        else begin nbad++; $error("FAIL drain got %0d pending want 0", q.size()); end
    endtask

    task automatic run_one(input logic [31:0] x, input logic [31:0] y, input logic sb, input logic ci);
        a = x; b = y; sub = sb; cin = ci;
        in_valid = 1'b1; out_ready = 1'b1; chk_lat = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (stg[sel] + 2) step();
        drain();
    endtask

    task automatic sweep(input int which);
        sel = which; chk_lat = 1'b1; out_ready = 1'b1;
        rand_beat();
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (acc) rand_beat();
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic check_idle(input string tag);
        ncmp++;
        assert ({o_ov, o_s, o_f, o_ir} === {1'b0, 32'h0, 3'b000, 1'b1})
        else begin nbad++; $error("FAIL %s got v=%b s=%h f=%b rdy=%b want v=0 s=0 f=000 rdy=1", tag, o_ov, o_s, o_f, o_ir); end
    endtask

    initial begin
        int n, t0;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        #3;
        for (int i = 0; i < 4; i++) begin
            sel = i;
            #1 check_idle("reset_state");
        end
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        sel = 0;
        run_one(32'h7F, 32'h01, 1'b0, 1'b0);
        run_one(32'h05, 32'h05, 1'b1, 1'b0);
        run_one(32'h03, 32'h04, 1'b1, 1'b0);
        sel = 1;
        run_one(32'hFF, 32'h00, 1'b0, 1'b1);

        sel = 0; chk_lat = 1'b0; n = 0; t0 = 0;
        rand_beat();
        in_valid = 1'b1;
        while (n < 16 && t0 < 300) begin
            out_ready = ((t0 / 3) % 2 == 0);
            step();
            t0++;
            if (acc) begin n++; rand_beat(); end
        end
        in_valid = 1'b0;
        ncmp++;
        assert (n == 16)
        else begin nbad++; $error("FAIL stream_accepts got %0d want 16", n); end
        for (int i = 0; i < 64 && q.size() > 0; i++) begin
            out_ready = ((t0 / 3) % 2 == 0);
            step();
            t0++;
        end
        out_ready = 1'b1;
        drain();

        sel = 1; chk_lat = 1'b1;
        rand_beat(); in_valid = 1'b1; step();
        rand_beat(); step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_idle("async_reset");
        q.delete();
        hold = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (8) step();
        run_one(32'h10, 32'h20, 1'b0, 1'b0);

        sweep(2);
        sweep(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshaking. It is the next generation of the team's gate-level 4-bit ripple-carry adder. Width is generalised, add/sub mode and status flags are added, and the carry chain is split across registered stages so wide operands meet timing. It sits between the operand register file and the ALU result mux, and is the datapath's sole integer add/sub unit.

## Interface
- `WIDTH`, 32: operand and result width in bits; must be ≥ 2.
- `STAGES`, 4: pipeline stages (latency); must divide `WIDTH`, 1 ≤ `STAGES` ≤ `WIDTH`.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `in_valid`  in  1: operand beat offered.
- `in_ready`  out  1: unit accepts a beat this cycle.
- `a`, `b`  in  `WIDTH`: operands.
- `sub`  in  1: 0 computes a+b+cin; 1 computes a−b (a + ~b + 1, `cin` ignored).
- `cin`  in  1: carry-in for add mode.
- `out_valid`  out  1: result beat present.
- `out_ready`  in  1: consumer accepts the result.
- `s`  out  `WIDTH`: result.
- `cout`  out  1: carry out of the MSB (in sub mode 1 = no borrow).
- `ovf`  out  1: signed overflow.
- `zero`  out  1: `s` == 0.

## Operation
- The operand is split into `STAGES` chunks of C = `WIDTH`/`STAGES` bits; stage k computes chunk k (LSB chunk first).
- Accept occurs when `in_valid` && `in_ready`. On accept, stage 0 registers chunk 0's sum, its carry, and the unprocessed upper operand chunks. In sub mode, `b` is inverted at capture and the chunk-0 carry-in is forced to 1.
- Each stage k > 0 adds its operand chunk plus the carry registered by stage k−1. It passes the completed low sum bits and the remaining upper chunks forward (skewed pipeline).
- Each stage carries a valid bit. The pipeline is a single global-stall design: advance = !`out_valid` || `out_ready`. When advance is 0, every stage register holds.
- `in_ready` = advance (combinational from `out_ready` and `out_valid`; no other path).
- Bubbles propagate as invalid stages. Results leave strictly in acceptance order; none is dropped or duplicated.
- Flags are computed in the last stage:
  - `ovf` = carry into MSB XOR carry out of MSB.
  - `zero` = ~|`s`.
  - `cout` is registered with `s`.
- `s`, `cout`, `ovf`, and `zero` are stable while `out_valid` && !`out_ready`. They are don't-care when `out_valid` = 0 but are held at their last value (no X).

## Timing
- Latency: a beat accepted at edge n appears with `out_valid` = 1 after edge n+`STAGES−1`, i.e. `STAGES` register stages.
- `STAGES` = 1 degenerates to a single registered full-width add.
- Throughput is 1 beat per cycle while `out_ready` = 1.
- On reset assertion (async, any cycle, including mid-pipeline), all stage valid bits go to 0 immediately. `out_valid`, `s`, `cout`, `ovf`, and `zero` = 0. In-flight beats are discarded.
- `in_ready` is 1 during and after reset, because `out_valid` = 0.
- Simultaneous accept and output handshake in the same cycle is legal and required for full throughput.
- Wrap-around: results are modulo 2^`WIDTH`; the carry is reported only via `cout`.

## Structure
- The shared package `alu_pkg` holds:
  - `ADDSUB_ADD` = 1'b0 and `ADDSUB_SUB` = 1'b1 mode constants.
  - The flag struct typedef {cout, ovf, zero}.
  - The default `WIDTH`/`STAGES` constants.
- Sub-module `addsub_slice` is a parametrised C-bit ripple adder built from the existing 1-bit full-adder cell (sum, cout, a, b, cin). It also exports carry-into-MSB for the overflow computation and is instantiated once per stage via generate.
- Stage registers and handshake live in `pipe_addsub`. Elaboration-time checks enforce the `WIDTH`/`STAGES` constraints.

## Test plan
- WIDTH=8, STAGES=2, add, cin=0: a=0x7F, b=0x01 → `s`=0x80, `ovf`=1, `cout`=0, `zero`=0, exactly 2 cycles after accept.
- WIDTH=8, STAGES=2, sub: a=0x05, b=0x05 → `s`=0x00, `zero`=1, `cout`=1, `ovf`=0. Then a=0x03, b=0x04 → `s`=0xFF, `cout`=0.
- WIDTH=8, STAGES=4, add, cin=1: a=0xFF, b=0x00 → carry ripples through all stages: `s`=0x00, `cout`=1, `zero`=1.
- Back-to-back stream of 16 random beats with `out_ready` toggling 1/0 every 3 cycles:
  - Outputs match the reference model in order.
  - `in_ready` tracks !`out_valid` || `out_ready`.
  - Output is held stable during stalls.
- Assert `rst_n`=0 for 1 cycle with 2 beats in flight → `out_valid` drops asynchronously and no stale beat emerges afterwards. The next accepted beat (a=0x10, b=0x20) yields 0x30.
- WIDTH=32, STAGES=1 and STAGES=32 sweeps → 1000 random add/sub beats match the model with latency 1 and 32 respectively.
